// File: rtl/adder4_seq_ctrl_if.sv
// Bundle between the multi-nibble add sequencer, its requester and the shared 4-bit adder.
// The master side drives requests and the adder results; the slave side is the sequencer.
interface adder4_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic [3:0]   add_s;
    logic         add_c4;

    modport master (
        output start, op_a, op_b, cin, add_s, add_c4,
        input  busy, done, sum, cout, add_a, add_b
    );

    modport slave (
        input  start, op_a, op_b, cin, add_s, add_c4,
        output busy, done, sum, cout, add_a, add_b
    );
endinterface

// File: rtl/adder4_seq_ctrl.sv
// Sequences a W-bit addition through an external carry-in-less 4-bit adder, LSB nibble first.
// An incoming carry costs an extra INC pass that adds 1 to the nibble's partial sum.
module adder4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    adder4_seq_ctrl_if.slave   bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             carry;
    logic [NIB_W-1:0] nib;
    logic [3:0]       tmp;
    logic             c_ab;
    logic             last_nib;
    logic             inc_carry;

    assign last_nib  = (nib == LAST_NIB);
    // A+B and +1 on the same nibble cannot both overflow, so OR merges them.
    assign inc_carry = c_ab | bus.add_c4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (carry) begin
                    state_next = INC;
                end else if (last_nib) begin
                    state_next = DONE;
                end else begin
                    state_next = ADD;
                end
            end
            INC: begin
                state_next = last_nib ? DONE : ADD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.add_a = 4'h0;
        bus.add_b = 4'h0;
        case (state)
            ADD: begin
                bus.busy  = 1'b1;
                bus.add_a = a_q[4*nib +: 4];
                bus.add_b = b_q[4*nib +: 4];
            end
            INC: begin
                bus.busy  = 1'b1;
                bus.add_a = tmp;
                bus.add_b = 4'h1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // Datapath: sum nibbles are written in place; cout only at the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            nib    <= '0;
            tmp    <= 4'h0;
            c_ab   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.op_a;
                        b_q   <= bus.op_b;
                        carry <= bus.cin;
                        nib   <= '0;
                    end
                end
                ADD: begin
                    if (carry) begin
                        tmp  <= bus.add_s;
                        c_ab <= bus.add_c4;
                    end else begin
                        sum_q[4*nib +: 4] <= bus.add_s;
                        carry             <= bus.add_c4;
                        if (last_nib) begin
                            cout_q <= bus.add_c4;
                        end else begin
                            nib <= nib + 1'b1;
                        end
                    end
                end
                INC: begin
                    sum_q[4*nib +: 4] <= bus.add_s;
                    carry             <= inc_carry;
                    if (last_nib) begin
                        cout_q <= inc_carry;
                    end else begin
                        nib <= nib + 1'b1;
                    end
                end
                default: begin
                    carry <= carry;
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Directed bench for adder4_seq_ctrl with a behavioural 4-bit adder beside it.
// Each result is compared against plain integer addition of the operands.
module tb_adder4_seq_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    adder4_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    adder4_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared adder: purely combinational, no carry-in.
    always_comb begin
        {bus.add_c4, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int expected_busy(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int   passes;
        logic carry_in;
        logic [4:0] t;
        passes   = NIBBLES;
        carry_in = c;
        for (int i = 0; i < NIBBLES; i++) begin
            if (carry_in) passes++;
            t        = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'h0, carry_in};
            carry_in = t[4];
        end
        return passes;
    endfunction

    task automatic apply_stimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input int exp_busy, input bit disturb);
        logic [W:0] ref_full;
        int         busy_cnt;
        int         done_cyc;
        int         extra_done;
        ref_full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.cin    = c;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        busy_cnt   = 0;
        done_cyc   = 0;
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            if (disturb && cyc == 2) begin
                bus.start = 1'b1;
                bus.op_a  = 16'hAAAA;
            end
            if (disturb && cyc == 3) bus.start = 1'b0;
            if (bus.done) begin
                done_cyc = cyc;
            end else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check_output({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_busy + 1));
        check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check_output({tag, "_sum"}, 32'(bus.sum), 32'(ref_full[W-1:0]));
        check_output({tag, "_cout"}, 32'(bus.cout), 32'(ref_full[W]));
        extra_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check_output({tag, "_extra_done"}, 32'(extra_done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           done_cnt;
        int           first_done;
        int           second_done;
        int           hold_bad;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_done", 32'(bus.done), 32'd0);
        check_output("reset_sum", 32'(bus.sum), 32'd0);
        check_output("reset_cout", 32'(bus.cout), 32'd0);
        check_output("reset_add_a", 32'(bus.add_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus("no_carry", 16'h1234, 16'h4321, 1'b0, 4, 1'b0);
        check_output("no_carry_sum_const", 32'(bus.sum), 32'h5555);
        apply_stimulus("ripple", 16'hFFFF, 16'h0001, 1'b0, 7, 1'b0);
        apply_stimulus("cin_all", 16'hFFFF, 16'h0000, 1'b1, 8, 1'b0);
        apply_stimulus("ignore_in", 16'h00F0, 16'h0010, 1'b0, 5, 1'b1);
        check_output("ignore_in_sum_const", 32'(bus.sum), 32'h0100);

        // Reset in the middle of an operation.
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h4321;
        bus.cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_busy", 32'(bus.busy), 32'd0);
        check_output("midrst_done", 32'(bus.done), 32'd0);
        check_output("midrst_sum", 32'(bus.sum), 32'd0);
        check_output("midrst_cout", 32'(bus.cout), 32'd0);
        hold_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) hold_bad++;
        end
        check_output("midrst_quiet", 32'(hold_bad), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus("post_rst", 16'h0001, 16'h0001, 1'b0, 4, 1'b0);

        // start held high: back-to-back operations, one IDLE cycle apart.
        bus.start   = 1'b1;
        bus.op_a    = 16'h8000;
        bus.op_b    = 16'h8000;
        bus.cin     = 1'b0;
        done_cnt    = 0;
        first_done  = 0;
        second_done = 0;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = cyc;
                if (done_cnt == 2) second_done = cyc;
                check_output("held_sum", 32'(bus.sum), 32'h0000);
                check_output("held_cout", 32'(bus.cout), 32'd1);
            end
        end
        bus.start = 1'b0;
        check_output("held_first_done", 32'(first_done), 32'd5);
        check_output("held_period", 32'(second_done - first_done), 32'd6);
        check_output("held_done_count", 32'(done_cnt), 32'd3);
        @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            apply_stimulus("random", ra, rb, rc, expected_busy(ra, rb, rc), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder4_seq_ctrl.md
Name: adder4_seq_ctrl

Overview:
Sequencer that runs multi-nibble additions through the shared 4-bit adder (A, B -> S, C4; no carry-in) one nibble per step, LSB first.
- Chains the carry between nibbles by inserting a +1 correction pass, because the adder has no carry-in.
- Sits beside the adder in the tt_um top level; the adder stays purely combinational and external to this block.

Parameters:
NIBBLES, 4, operand width in nibbles; operand/sum width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op_a  in  W  operand A; captured on the accepted start
op_b  in  W  operand B; captured on the accepted start
cin  in  1  carry-in; captured on the accepted start
busy  out  1  high in ADD and INC states
done  out  1  one-cycle pulse; high in DONE state
sum  out  W  result register
cout  out  1  result carry-out register
add_a  out  4  to adder A
add_b  out  4  to adder B
add_s  in  4  from adder S (same-cycle combinational)
add_c4  in  1  from adder C4

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, cout = 0; sum = 0; internal operands, nibble index, carry and temp registers = 0. Reset applies immediately when asserted, including mid-operation; the in-flight operation is discarded.
- States: IDLE, ADD, INC, DONE.
- IDLE:
  - add_a = add_b = 0.
  - At an edge with start=1: latch op_a, op_b; carry <= cin; nib <= 0; go to ADD.
- ADD:
  - Drive add_a = A[nib], add_b = B[nib].
  - At the edge: if carry=0, write add_s to sum[nib], carry <= add_c4, then advance.
  - If carry=1: tmp <= add_s, c_ab <= add_c4, go to INC.
- INC:
  - Drive add_a = tmp, add_b = 4'h1.
  - At the edge: write add_s to sum[nib], carry <= c_ab | add_c4, then advance.
  - c_ab and add_c4 are never both 1.
- Advance: if nib == NIBBLES-1, cout <= final carry and go to DONE. Otherwise nib <= nib+1 and go to ADD.
- DONE:
  - done=1 and busy=0 for exactly one cycle; add_a = add_b = 0.
  - Next state is always IDLE. start is ignored in DONE.
- sum nibbles update in place during the operation. sum and cout are final from the DONE cycle and hold until the next accepted start's write-backs.
- start, op_a, op_b and cin are ignored in ADD, INC and DONE. Input changes during an operation do not affect the result.
- Latency: cycles from the accepting edge to the done cycle = NIBBLES + (number of INC passes) + 1.
  - Minimum NIBBLES+1; maximum 2*NIBBLES+1.
  - INC occurs for a nibble iff the carry into it is 1.
- start held high continuously: a new operation is accepted at the edge ending the IDLE cycle that follows DONE, i.e. one idle cycle between operations.
- Arithmetic: {cout, sum} = op_a + op_b + cin, exact modulo 2^(W+1).
- Sampling: add_s and add_c4 are sampled only at edges in ADD and INC; their values in other states are don't-care.

Test Plan:
- NIBBLES=4, op_a=16'h1234, op_b=16'h4321, cin=0, start pulse -> no INC; busy for 4 cycles, done on cycle 5; sum=16'h5555, cout=0.
- op_a=16'hFFFF, op_b=16'h0001, cin=0 -> INC on nibbles 1-3; 7 busy cycles, done on cycle 8; sum=16'h0000, cout=1.
- op_a=16'hFFFF, op_b=16'h0000, cin=1 -> INC on every nibble; 8 busy cycles, done on cycle 9; sum=16'h0000, cout=1.
- op_a=16'h00F0, op_b=16'h0010, cin=0; during busy, pulse start and change op_a to 16'hAAAA -> both ignored; sum=16'h0100, cout=0, a single done pulse.
- Assert rst_n=0 mid-operation (2 cycles after start) -> busy, done, sum, cout = 0 immediately, no done pulse. Then release reset and start 16'h0001+16'h0001 -> sum=16'h0002.
- start held high with op_a=16'h8000, op_b=16'h8000 -> first op: sum=0, cout=1. done, one IDLE cycle, next op accepted automatically, and done pulses repeat with period (busy cycles + 2). Cross-check every result against op_a+op_b+cin with a random reference model.
